mux_arb: RTL and testbench
==========================

MUX_ARB -- requirements
Module: mux_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width per channel.
REQ-002 SHALL have parameter N_CH, default 4: input channel count, legal range 2..16.
REQ-003 SHALL have parameter MODE, type mux_mode_e, default MUX_RR: MUX_SEL uses external select; MUX_RR uses round-robin arbitration.
REQ-004 SHALL have one clock, clk (input, 1): all state updates on its rising edge.
REQ-005 SHALL have reset rst (input, 1): asynchronous, active-high.
REQ-006 SHALL have in_data (input, N_CH x WIDTH): per-channel payload.
REQ-007 SHALL have in_valid (input, N_CH): per-channel payload valid.
REQ-008 SHALL have in_last (input, N_CH): per-channel end-of-packet marker.
REQ-009 SHALL have in_ready (output, N_CH): per-channel accept.
REQ-010 SHALL have sel_mux (input, $clog2(N_CH)): channel select, used only when MODE==MUX_SEL.
REQ-011 SHALL have out_data (output, WIDTH), out_valid (output, 1), out_last (output, 1) and out_ready (input, 1).
REQ-012 SHALL have out_ch (output, $clog2(N_CH)): source channel of the registered output word.

Function
REQ-013 SHALL register the output: a word accepted in cycle t appears on out_data/out_valid in cycle t+1 (latency 1).
REQ-014 SHALL accept from a channel i only when in_valid[i] && in_ready[i]; transfer out only when out_valid && out_ready.
REQ-015 SHALL drive in_ready[i] = grant[i] && (!out_valid || out_ready), allowing full throughput of one word per cycle.
REQ-016 SHALL assert at most one grant bit per cycle; the grant is combinational from the current state and in_valid.
REQ-017 In MUX_SEL mode: grant[sel_mux] = 1 only; if sel_mux >= N_CH, no grant is issued and in_ready is all zeros.
REQ-018 In MUX_RR mode: the grant goes to the first valid channel at or after pointer rr_ptr, with wrap-around from N_CH-1 to 0.
REQ-019 In MUX_RR mode: after each accepted word, rr_ptr SHALL become (granted channel + 1) mod N_CH; rr_ptr is unchanged when nothing is accepted.
REQ-020 SHALL hold out_data, out_last and out_ch stable while out_valid && !out_ready.
REQ-021 If no word is accepted and the output transfers, out_valid SHALL drop to 0 in the next cycle.
REQ-022 SHALL copy in_last[i] of the accepted channel to out_last.

Reset
REQ-023 While rst is high: out_valid=0, out_data=0, out_last=0, out_ch=0, rr_ptr=0, state=ARB, and in_ready all zeros.
REQ-024 Assertion of rst mid-packet or mid-stall SHALL discard the held word without a handshake; after reset, operation resumes in state ARB.

Configuration
REQ-025 Macro MUX_ARB_LOCK_EN defined: two-state FSM ARB/LOCK; ARB->LOCK on acceptance of a word with in_last=0, holding the grant on that channel; LOCK->ARB on acceptance of a word with in_last=1 from the locked channel.
REQ-026 With MUX_ARB_LOCK_EN: in LOCK, other channels get no grant regardless of in_valid or sel_mux changes, and rr_ptr does not advance until unlock.
REQ-027 Without MUX_ARB_LOCK_EN: state is permanently ARB, in_last is only forwarded to out_last, and arbitration happens on every word.

Structure
REQ-028 Shared package mux_pkg SHALL hold typedef enum mux_mode_e {MUX_SEL, MUX_RR} and typedef enum arb_state_e {ARB, LOCK}.
REQ-029 Round-robin grant logic SHALL be a sub-module rr_arbiter (inputs req, ptr; output one-hot gnt); mux_arb instantiates it.

Verification
REQ-030 MUX_RR, N_CH=4, in_valid=4'b1111, out_ready=1 continuously -> out_ch sequence 0,1,2,3,0 on consecutive cycles, one word per cycle.
REQ-031 MUX_RR, in_valid=4'b1010, rr_ptr=2 -> ch3 granted, then ch1 (wrap-around), then ch3.
REQ-032 Output stall: word 0xDEADBEEF held with out_ready=0 for 3 cycles -> out_data is stable, in_ready=0, then transfers on the cycle out_ready=1.
REQ-033 MUX_SEL, sel_mux=2, in_valid=4'b0111 -> only ch2 accepted; sel_mux=3 with in_valid[3]=0 -> out_valid drops after drain.
REQ-034 MUX_ARB_LOCK_EN: ch1 sends 3 words (last on 3rd) while ch0 and ch2 are valid -> out_ch=1,1,1, then ch2 next.
REQ-035 Assert rst while out_valid=1 and state=LOCK -> all outputs 0 in the same cycle; the first post-reset grant goes to ch0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types for the mux_arb output multiplexer and its round-robin arbiter.
package mux_pkg;

  typedef enum logic {
    MUX_SEL,
    MUX_RR
  } mux_mode_e;

  typedef enum logic {
    ARB,
    LOCK
  } arb_state_e;

endpackage

// File: rtl/mux_arb_rr_arbiter.sv
// Round-robin grant: first requester at or after ptr, wrapping N-1 -> 0.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      logic [PW-1:0] k;
      k = PW'((int'(ptr) + i) % N);
      if (!found && req[k]) begin
        gnt[k] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_arb.sv
// N-channel to one registered multiplexer, external-select or round-robin.
// Optional packet locking is enabled with the MUX_ARB_LOCK_EN macro.
module mux_arb
  import mux_pkg::*;
#(
  parameter int        WIDTH = 32,
  parameter int        N_CH  = 4,
  parameter mux_mode_e MODE  = MUX_RR,
  localparam int       SW    = $clog2(N_CH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_CH-1:0][WIDTH-1:0]  in_data,
  input  logic [N_CH-1:0]             in_valid,
  input  logic [N_CH-1:0]             in_last,
  output logic [N_CH-1:0]             in_ready,
  input  logic [SW-1:0]               sel_mux,
  output logic [WIDTH-1:0]            out_data,
  output logic                        out_valid,
  output logic                        out_last,
  input  logic                        out_ready,
  output logic [SW-1:0]               out_ch
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [SW-1:0]    out_ch_q, out_ch_d;
  logic [SW-1:0]    rr_ptr_q, rr_ptr_d;
  arb_state_e       state_q, state_d;

  logic [N_CH-1:0]  rr_gnt;
  logic [N_CH-1:0]  grant;
  logic [SW-1:0]    gidx;
  logic             can_take;
  logic             accept;

`ifdef MUX_ARB_LOCK_EN
  logic [SW-1:0]    lock_ch_q, lock_ch_d;
`endif

  rr_arbiter #(
    .N  (N_CH),
    .PW (SW)
  ) u_rr (
    .req (in_valid),
    .ptr (rr_ptr_q),
    .gnt (rr_gnt)
  );

  always_comb begin
    grant = '0;
`ifdef MUX_ARB_LOCK_EN
    if (state_q == LOCK) begin
      grant[lock_ch_q] = 1'b1;
    end else
`endif
    if (MODE == MUX_SEL) begin
      if (int'(sel_mux) < N_CH) begin
        grant[sel_mux] = 1'b1;
      end
    end else begin
      grant = rr_gnt;
    end
  end

  always_comb begin
    gidx = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) begin
        gidx = SW'(i);
      end
    end
  end

  // The output register can load whenever it is empty or draining now.
  assign can_take = !out_valid_q || out_ready;
  assign in_ready = rst ? '0 : (grant & {N_CH{can_take}});
  assign accept   = |(in_valid & in_ready);

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    state_d     = ARB;
`ifdef MUX_ARB_LOCK_EN
    state_d     = state_q;
    lock_ch_d   = lock_ch_q;
`endif
    if (accept) begin
      out_data_d  = in_data[gidx];
      out_valid_d = 1'b1;
      out_last_d  = in_last[gidx];
      out_ch_d    = gidx;
      // While locked gidx is the locked channel, so the pointer stays put.
      if (MODE == MUX_RR) begin
        rr_ptr_d = (int'(gidx) == N_CH - 1) ? '0 : gidx + SW'(1);
      end
`ifdef MUX_ARB_LOCK_EN
      if (state_q == ARB && !in_last[gidx]) begin
        state_d   = LOCK;
        lock_ch_d = gidx;
      end else if (state_q == LOCK && in_last[gidx]) begin
        state_d   = ARB;
      end
`endif
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
      state_q     <= ARB;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
      state_q     <= state_d;
    end
  end

`ifdef MUX_ARB_LOCK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_ch_q <= '0;
    end else begin
      lock_ch_q <= lock_ch_d;
    end
  end
`endif

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_arb.sv
// Directed checks of mux_arb in round-robin and external-select modes.
module tb_mux_arb;
  import mux_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0][31:0] in_data;
  logic [3:0]       in_valid;
  logic [3:0]       in_last;
  logic             out_ready;
  logic [1:0]       sel_mux;

  logic [3:0]  r_in_ready, s_in_ready;
  logic [31:0] r_out_data, s_out_data;
  logic        r_out_valid, s_out_valid;
  logic        r_out_last, s_out_last;
  logic [1:0]  r_out_ch, s_out_ch;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux_arb #(.WIDTH(32), .N_CH(4), .MODE(MUX_RR)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (r_in_ready),
    .sel_mux   (sel_mux),
    .out_data  (r_out_data),
    .out_valid (r_out_valid),
    .out_last  (r_out_last),
    .out_ready (out_ready),
    .out_ch    (r_out_ch)
  );

  mux_arb #(.WIDTH(32), .N_CH(4), .MODE(MUX_SEL)) u_sel (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (s_in_ready),
    .sel_mux   (sel_mux),
    .out_data  (s_out_data),
    .out_valid (s_out_valid),
    .out_last  (s_out_last),
    .out_ready (out_ready),
    .out_ch    (s_out_ch)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 4'b1111;
    in_last   = 4'b0000;
    out_ready = 1'b1;
    sel_mux   = 2'd0;
    for (int i = 0; i < 4; i++) in_data[i] = 32'hC0DE_0000 + i;
    tick();
    tick();

    chk("rst_valid", 64'(r_out_valid), 64'd0);
    chk("rst_data", 64'(r_out_data), 64'd0);
    chk("rst_last", 64'(r_out_last), 64'd0);
    chk("rst_ch", 64'(r_out_ch), 64'd0);
    chk("rst_rdy", 64'(r_in_ready), 64'd0);
    chk("rst_rdy_sel", 64'(s_in_ready), 64'd0);

    // Round-robin, all channels busy.
    rst = 1'b0;
    #1;
    chk("rr_rdy0", 64'(r_in_ready), 64'h1);
    tick();
    chk("rr_ch0", 64'(r_out_ch), 64'd0);
    chk("rr_dat0", 64'(r_out_data), 64'hC0DE_0000);
    chk("rr_v0", 64'(r_out_valid), 64'd1);
    tick();
    chk("rr_ch1", 64'(r_out_ch), 64'd1);
    tick();
    chk("rr_ch2", 64'(r_out_ch), 64'd2);
    tick();
    chk("rr_ch3", 64'(r_out_ch), 64'd3);
    chk("rr_dat3", 64'(r_out_data), 64'hC0DE_0003);
    tick();
    chk("rr_ch0b", 64'(r_out_ch), 64'd0);
    chk("rr_v4", 64'(r_out_valid), 64'd1);

    // Sparse requesters with wrap-around.
    do_reset();
    in_valid = 4'b1010;
    tick();
    chk("sp_ch1", 64'(r_out_ch), 64'd1);
    tick();
    chk("sp_ch3", 64'(r_out_ch), 64'd3);
    tick();
    chk("sp_wrap1", 64'(r_out_ch), 64'd1);
    tick();
    chk("sp_ch3b", 64'(r_out_ch), 64'd3);

    // Output stall.
    do_reset();
    in_valid   = 4'b0001;
    in_data[0] = 32'hDEAD_BEEF;
    out_ready  = 1'b0;
    tick();
    in_data[0] = 32'h1234_5678;
    chk("st_v", 64'(r_out_valid), 64'd1);
    chk("st_dat0", 64'(r_out_data), 64'hDEAD_BEEF);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("st_hold", 64'(r_out_data), 64'hDEAD_BEEF);
      chk("st_vhold", 64'(r_out_valid), 64'd1);
      chk("st_rdy0", 64'(r_in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("st_rdy1", 64'(r_in_ready), 64'h1);
    tick();
    chk("st_next", 64'(r_out_data), 64'h1234_5678);
    in_valid = 4'b0000;
    tick();
    chk("st_drop", 64'(r_out_valid), 64'd0);
    chk("st_keep", 64'(r_out_data), 64'h1234_5678);
    in_data[0] = 32'hC0DE_0000;

    // External select.
    do_reset();
    sel_mux  = 2'd2;
    in_valid = 4'b0111;
    #1;
    chk("sel_rdy2", 64'(s_in_ready), 64'h4);
    tick();
    chk("sel_ch2", 64'(s_out_ch), 64'd2);
    chk("sel_dat2", 64'(s_out_data), 64'hC0DE_0002);
    tick();
    chk("sel_ch2b", 64'(s_out_ch), 64'd2);
    chk("sel_v2b", 64'(s_out_valid), 64'd1);
    sel_mux = 2'd3;
    #1;
    chk("sel_rdy3", 64'(s_in_ready), 64'h8);
    tick();
    chk("sel_drain", 64'(s_out_valid), 64'd0);

    // Packet from ch1 competing with ch0 and ch2.
    do_reset();
    sel_mux  = 2'd0;
    in_valid = 4'b0010;
    in_last  = 4'b0000;
    tick();
    chk("pk_w1", 64'(r_out_ch), 64'd1);
    in_valid = 4'b0111;
`ifdef MUX_ARB_LOCK_EN
    #1;
    chk("pk_lockrdy", 64'(r_in_ready), 64'h2);
    tick();
    chk("pk_w2", 64'(r_out_ch), 64'd1);
    in_last = 4'b0010;
    tick();
    chk("pk_w3", 64'(r_out_ch), 64'd1);
    chk("pk_last", 64'(r_out_last), 64'd1);
    in_last = 4'b0000;
    tick();
    chk("pk_ch2", 64'(r_out_ch), 64'd2);
`else
    tick();
    chk("pk_ch2", 64'(r_out_ch), 64'd2);
    tick();
    chk("pk_ch0", 64'(r_out_ch), 64'd0);
    tick();
    chk("pk_ch1", 64'(r_out_ch), 64'd1);
`endif

    // Reset while holding a word (and while locked when enabled).
    do_reset();
    in_valid = 4'b0010;
    in_last  = 4'b0000;
    out_ready = 1'b0;
    tick();
    chk("mr_v", 64'(r_out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("mr_v0", 64'(r_out_valid), 64'd0);
    chk("mr_d0", 64'(r_out_data), 64'd0);
    chk("mr_ch0", 64'(r_out_ch), 64'd0);
    chk("mr_rdy0", 64'(r_in_ready), 64'd0);
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    in_valid  = 4'b0111;
    #1;
    chk("mr_first", 64'(r_in_ready), 64'h1);
    tick();
    chk("mr_ch", 64'(r_out_ch), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=done");
    $fatal(1, "timeout");
  end

endmodule
